// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter that owns the load sequencing of a shared
// PIPO register and hands its word downstream with valid/ready.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   req, req_data       per-requester level request and packed words
//   gnt                 registered one-cycle one-hot grant pulse
//   data_out, owner     held word and index of the requester it came from
//   out_valid, busy     word pending downstream (busy mirrors out_valid)
//   out_ready           downstream accept
//   grant_count         wrapping count of grants
module pipo_load_arbiter #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int CNTW    = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         data_out,
  output logic [IDW-1:0]           owner,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [CNTW-1:0]          grant_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [IDW-1:0]       rr_q;
  logic                 win_hit;
  logic [IDW-1:0]       win_idx;
  logic [WIDTH-1:0]     win_data;
  logic [IDW-1:0]       rr_nxt;
  logic                 capture;
  logic [NUM_REQ-1:0]   gnt_d;
  int                   idx;

  // Search req starting at rr, wrapping; first hit wins.
  always_comb begin
    win_hit  = 1'b0;
    win_idx  = '0;
    win_data = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_hit && req[idx]) begin
        win_hit  = 1'b1;
        win_idx  = IDW'(idx);
        win_data = req_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  assign rr_nxt = (int'(win_idx) == NUM_REQ - 1) ?
                  '0 : win_idx + IDW'(1);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (win_hit)   state_d = VALID;
      VALID: if (out_ready) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Output / load-control logic
  always_comb begin
    capture = (state_q == IDLE) && win_hit;
    gnt_d   = '0;
    for (int k = 0; k < NUM_REQ; k++)
      gnt_d[k] = capture && (int'(win_idx) == k);
  end

  assign out_valid = (state_q == VALID);
  assign busy      = out_valid;

  // Held register, grant pulse, pointer and counter
  always_ff @(posedge clock) begin
    if (reset) begin
      gnt         <= '0;
      data_out    <= '0;
      owner       <= '0;
      rr_q        <= '0;
      grant_count <= '0;
    end else begin
      gnt <= gnt_d;
      if (capture) begin
        data_out    <= win_data;
        owner       <= win_idx;
        rr_q        <= rr_nxt;
        grant_count <= grant_count + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Bench for pipo_load_arbiter: vector table, corner sequences,
// and random traffic against a behavioural reference model.
module tb_pipo_load_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic        out_ready;
  logic [3:0]  gnt;
  logic [3:0]  data_out;
  logic [1:0]  owner;
  logic        out_valid;
  logic        busy;
  logic [7:0]  grant_count;

  logic [3:0]  gnt2;
  logic [3:0]  data_out2;
  logic [1:0]  owner2;
  logic        out_valid2;
  logic        busy2;
  logic [1:0]  grant_count2;

  int checks = 0;
  int failures = 0;

  pipo_load_arbiter #(.WIDTH(4), .NUM_REQ(4), .IDW(2), .CNTW(8)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
    .gnt(gnt), .data_out(data_out), .owner(owner),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .grant_count(grant_count)
  );

  pipo_load_arbiter #(.WIDTH(4), .NUM_REQ(4), .IDW(2), .CNTW(2)) dut2 (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
    .gnt(gnt2), .data_out(data_out2), .owner(owner2),
    .out_valid(out_valid2), .out_ready(out_ready), .busy(busy2),
    .grant_count(grant_count2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state
  bit         m_vld;
  int         m_rr;
  int         m_own;
  int         m_cnt;
  logic [3:0] m_data;
  logic [3:0] m_gnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int w;
    if (reset) begin
      m_vld = 0; m_rr = 0; m_own = 0; m_cnt = 0;
      m_data = '0; m_gnt = '0;
    end else if (!m_vld) begin
      m_gnt = '0;
      if (req != 0) begin
        w = -1;
        for (int k = 0; k < 4; k++)
          if (w < 0 && req[(m_rr + k) % 4]) w = (m_rr + k) % 4;
        m_data = req_data[w*4 +: 4];
        m_own  = w;
        m_gnt  = 4'(1 << w);
        m_vld  = 1;
        m_cnt  = (m_cnt + 1) % 256;
        m_rr   = (w + 1) % 4;
      end
    end else begin
      m_gnt = '0;
      if (out_ready) m_vld = 0;
    end
  endtask

  task automatic check_model();
    chk("model_gnt", 32'(gnt), 32'(m_gnt));
    chk("model_data", 32'(data_out), 32'(m_data));
    chk("model_owner", 32'(owner), 32'(m_own));
    chk("model_valid", 32'(out_valid), 32'(m_vld));
    chk("model_busy", 32'(busy), 32'(m_vld));
    chk("model_count", 32'(grant_count), 32'(m_cnt));
    chk("model_count2", 32'(grant_count2), 32'(m_cnt % 4));
  endtask

  task automatic apply(input logic r, input logic [3:0] q,
                       input logic [15:0] d, input logic rd);
    reset = r; req = q; req_data = d; out_ready = rd;
    @(posedge clock);
    model_step();
    #1;
    check_model();
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] data;
    logic        rdy;
    logic [3:0]  gnt;
    logic [3:0]  dout;
    logic [1:0]  own;
    logic        vld;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vt[16];
  logic [1:0] wrap_exp[5];
  logic [1:0] own_exp[5];

  initial begin
    reset = 1'b1; req = '0; req_data = '0; out_ready = 1'b0;
    m_vld = 0; m_rr = 0; m_own = 0; m_cnt = 0;
    m_data = '0; m_gnt = '0;

    vt[0]  = '{1'b1, 4'hF, 16'h0000, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 8'd0};
    vt[1]  = '{1'b1, 4'hF, 16'h0000, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 8'd0};
    vt[2]  = '{1'b0, 4'h1, 16'h000B, 1'b1, 4'h1, 4'hB, 2'd0, 1'b1, 8'd1};
    vt[3]  = '{1'b0, 4'h0, 16'h000B, 1'b1, 4'h0, 4'hB, 2'd0, 1'b0, 8'd1};
    vt[4]  = '{1'b1, 4'h0, 16'h0000, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 8'd0};
    vt[5]  = '{1'b0, 4'hF, 16'h4321, 1'b1, 4'h1, 4'h1, 2'd0, 1'b1, 8'd1};
    vt[6]  = '{1'b0, 4'hF, 16'h4321, 1'b1, 4'h0, 4'h1, 2'd0, 1'b0, 8'd1};
    vt[7]  = '{1'b0, 4'hF, 16'h4321, 1'b1, 4'h2, 4'h2, 2'd1, 1'b1, 8'd2};
    vt[8]  = '{1'b0, 4'hF, 16'h4321, 1'b1, 4'h0, 4'h2, 2'd1, 1'b0, 8'd2};
    vt[9]  = '{1'b0, 4'hF, 16'h4321, 1'b1, 4'h4, 4'h3, 2'd2, 1'b1, 8'd3};
    vt[10] = '{1'b0, 4'hF, 16'h4321, 1'b1, 4'h0, 4'h3, 2'd2, 1'b0, 8'd3};
    vt[11] = '{1'b0, 4'hF, 16'h4321, 1'b1, 4'h8, 4'h4, 2'd3, 1'b1, 8'd4};
    vt[12] = '{1'b0, 4'hF, 16'h4321, 1'b1, 4'h0, 4'h4, 2'd3, 1'b0, 8'd4};
    vt[13] = '{1'b0, 4'hF, 16'h4321, 1'b1, 4'h1, 4'h1, 2'd0, 1'b1, 8'd5};
    vt[14] = '{1'b0, 4'hF, 16'h4321, 1'b1, 4'h0, 4'h1, 2'd0, 1'b0, 8'd5};
    vt[15] = '{1'b0, 4'h4, 16'h0600, 1'b0, 4'h4, 4'h6, 2'd2, 1'b1, 8'd6};

    for (int i = 0; i < 16; i++) begin
      apply(vt[i].rst, vt[i].req, vt[i].data, vt[i].rdy);
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vt[i].gnt));
      chk($sformatf("vec%0d_data", i), 32'(data_out), 32'(vt[i].dout));
      chk($sformatf("vec%0d_owner", i), 32'(owner), 32'(vt[i].own));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].vld));
      chk($sformatf("vec%0d_count", i), 32'(grant_count), 32'(vt[i].cnt));
    end

    // Backpressure: owner 2 held for 10 cycles, then accept.
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 4'b1011, 16'hA065, 1'b0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(data_out), 32'h6);
      chk("bp_gnt", 32'(gnt), 32'd0);
    end
    apply(1'b0, 4'b0000, 16'hA065, 1'b1);
    chk("bp_accept_valid", 32'(out_valid), 32'd0);
    chk("bp_accept_data", 32'(data_out), 32'h6);
    apply(1'b0, 4'b1011, 16'hA065, 1'b0);
    chk("bp_next_owner", 32'(owner), 32'd3);
    chk("bp_next_gnt", 32'(gnt), 32'h8);
    chk("bp_next_data", 32'(data_out), 32'hA);

    // Reset while a word is pending.
    apply(1'b1, 4'b0000, 16'h0000, 1'b0);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_data", 32'(data_out), 32'd0);
    chk("rst_mid_owner", 32'(owner), 32'd0);
    chk("rst_mid_count", 32'(grant_count), 32'd0);

    // Five grants: req 1000 first, then 1111; rr restarts at 0.
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;
    own_exp[0] = 2'd3; own_exp[1] = 2'd0; own_exp[2] = 2'd1;
    own_exp[3] = 2'd2; own_exp[4] = 2'd3;
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, (i == 0) ? 4'b1000 : 4'b1111, 16'h4321, 1'b0);
      chk($sformatf("wrap%0d_count2", i), 32'(grant_count2),
          32'(wrap_exp[i]));
      chk($sformatf("wrap%0d_owner", i), 32'(owner), 32'(own_exp[i]));
      apply(1'b0, 4'b0000, 16'h4321, 1'b1);
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      apply(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
            16'($urandom),
            ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipo_load_arbiter.md
Name: pipo_load_arbiter

Overview:
- Shares one WIDTH-bit parallel-in/parallel-out holding register among NUM_REQ requesters using round-robin arbitration.
- Captures the winner's word, presents it downstream with a valid/ready handshake, and returns each winner a one-cycle grant pulse.
- Sits between the requesting producers and the shared PIPO data register; it owns that register's load sequencing.

Parameters:
- WIDTH, 4, data word width.
- NUM_REQ, 4, number of requesters (2..8).
- IDW, 2, owner-id width; must be at least clog2(NUM_REQ).
- CNTW, 8, width of the grant counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester load request, level.
- req_data  input  NUM_REQ*WIDTH  requester i's word at bits [i*WIDTH +: WIDTH].
- gnt  output  NUM_REQ  registered one-hot grant pulse, one cycle.
- data_out  output  WIDTH  held register contents.
- owner  output  IDW  index of the requester whose word is in data_out.
- out_valid  output  1  data_out holds a word not yet accepted downstream.
- out_ready  input  1  downstream accepts data_out when high with out_valid.
- busy  output  1  high in the VALID state (equal to out_valid).
- grant_count  output  CNTW  total number of grants, wraps modulo 2^CNTW.

Behaviour:
- Reset has priority over all other events and is sampled at the clock edge, including mid-transfer. It forces:
  - state to IDLE; gnt=0, data_out=0, owner=0, out_valid=0, busy=0, grant_count=0;
  - round-robin pointer rr=0.
- FSM states: IDLE, VALID.
- IDLE, with any req bit high at the edge:
  - winner w = first set bit of req, searching from index rr upward and wrapping modulo NUM_REQ.
  - At that edge: data_out<=req_data[w], owner<=w, gnt<=onehot(w), out_valid<=1, grant_count<=grant_count+1, rr<=(w+1) mod NUM_REQ; state goes to VALID.
- IDLE with req==0: no change; gnt=0.
- VALID:
  - gnt returns to 0 after its single cycle.
  - req is ignored; data_out and owner stay stable.
  - At an edge with out_ready=1, transfer completes: out_valid<=0, state goes to IDLE. data_out and owner keep their values.
  - out_ready=0 holds the state indefinitely; there is no timeout.
- Latency:
  - req to gnt/data_out update: 1 edge.
  - Minimum spacing between consecutive grants: 2 cycles (capture edge, accept edge, then the next capture edge).
- Requester protocol:
  - Hold req and the data word stable until gnt is seen.
  - A req still high after gnt is treated as a new request. It gets lowest priority because rr has moved past it.
- out_ready while out_valid=0: ignored.
- Single requester: rr wraps past it, and the search still finds the same requester again.
- grant_count: increments only on a capture edge; 2^CNTW-1 wraps to 0.
- Only one gnt bit is ever high. gnt never asserts in VALID or during reset.

Test Plan:
- Reset: reset=1 for 2 edges with req=4'b1111 -> gnt=0, data_out=0, out_valid=0, grant_count=0, rr=0.
- Single load: after reset, req=4'b0001 with req_data[3:0]=4'b1011 and out_ready=1 -> next edge: data_out=4'b1011, owner=0, gnt=4'b0001 for one cycle, out_valid=1; following edge out_valid=0, data_out stays 4'b1011.
- Round-robin: req=4'b1111 held, words 1/2/3/4 for requesters 0..3, out_ready=1 -> owners granted in order 0,1,2,3,0, one grant every 2 cycles; grant_count reaches 5.
- Backpressure: grant owner 2 (word 4'b0110), out_ready=0 for 10 cycles while req=4'b1011 -> out_valid stays 1, data_out stays 4'b0110, no gnt pulses. Then out_ready=1 -> IDLE, and the next grant goes to requester 3 (search starts at rr=3).
- Reset mid-transfer: reset=1 while out_valid=1 -> next edge out_valid=0, data_out=0, owner=0, grant_count=0. With req=4'b1000 afterwards, requester 3 wins and rr becomes 0.
- Wrap: CNTW=2, 5 grants -> grant_count sequence 1,2,3,0,1.
